// File: rtl/dma_axi_pkg.sv
// Shared AXI constants, state encoding and helpers for the DMA burst masters.
package dma_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } dma_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// Beats for the next burst: limited by what is left, by MAX_BURST and by the 4 KB page end.
module axi_burst_calc
    import dma_axi_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    localparam int OFF_W    = clog2(DATA_W / 8),
    localparam int BEAT_W   = clog2(MAX_BURST) + 1
) (
    input  logic [11:0]       page_off,
    input  logic [LEN_W-1:0]  remaining,
    output logic [BEAT_W-1:0] beats
);

    localparam int CW = (LEN_W > 13) ? LEN_W : 13;

    logic [12:0]   page_bytes;
    logic [CW-1:0] page_beats;
    logic [CW-1:0] rem_c;
    logic [CW-1:0] max_c;
    logic [CW-1:0] min_a;
    logic [CW-1:0] min_b;

    // page_off is aligned, so the division by BYTES is exact
    assign page_bytes = 13'h1000 - {1'b0, page_off};
    assign page_beats = CW'(page_bytes >> OFF_W);
    assign rem_c      = CW'(remaining);
    assign max_c      = CW'(MAX_BURST);
    assign min_a      = (rem_c < max_c) ? rem_c : max_c;
    assign min_b      = (min_a < page_beats) ? min_a : page_beats;
    assign beats      = BEAT_W'(min_b);

endmodule

// File: rtl/axi_burst_write_master.sv
// DMA write-side AXI4 master: drains a show-ahead FIFO into memory as 4 KB-safe INCR bursts,
// one burst outstanding, with a done pulse and sticky error summary.
//
// state   | meaning
// IDLE    | waiting for wr_start
// CALC    | size next burst, load AW channel
// AW      | awvalid held until awready
// W       | stream beats from FIFO, wlast on final beat
// B       | bready high, waiting for write response
// DONE    | one-cycle wr_done with accumulated wr_err
module axi_burst_write_master
    import dma_axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16,
    localparam int BYTES    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_start,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    output logic              wr_done,
    output logic              wr_err,
    output logic              wr_busy,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [BYTES-1:0]  m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              fifo_empty,
    output logic              fifo_ren
);

    localparam int OFF_W  = clog2(BYTES);
    localparam int BEAT_W = clog2(MAX_BURST) + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    dma_state_e        state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] calc_beats;
    logic              err_acc;
    logic              w_hs;

    axi_burst_calc #(
        .LEN_W     (LEN_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) u_calc (
        .page_off  (addr[11:0]),
        .remaining (remaining),
        .beats     (calc_beats)
    );

    // W data comes straight from the FIFO head; a pop happens only on handshake
    assign m_axi_wvalid  = (state == ST_W) && !fifo_empty;
    assign m_axi_wlast   = (state == ST_W) && (beat_cnt == BEAT_W'(1));
    assign m_axi_wdata   = fifo_rdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_awsize  = 3'(OFF_W);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign w_hs          = m_axi_wvalid && m_axi_wready;
    assign fifo_ren      = w_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            addr          <= '0;
            remaining     <= '0;
            beat_cnt      <= '0;
            err_acc       <= 1'b0;
            wr_done       <= 1'b0;
            wr_err        <= 1'b0;
            wr_busy       <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_start) begin
                        addr      <= wr_addr & ALIGN_MASK;
                        remaining <= wr_len;
                        err_acc   <= 1'b0;
                        wr_busy   <= 1'b1;
                        state     <= (wr_len == '0) ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    m_axi_awaddr  <= addr;
                    m_axi_awlen   <= 8'(calc_beats - BEAT_W'(1));
                    beat_cnt      <= calc_beats;
                    m_axi_awvalid <= 1'b1;
                    state         <= ST_AW;
                end
                ST_AW: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        state         <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        beat_cnt  <= beat_cnt - BEAT_W'(1);
                        addr      <= addr + ADDR_W'(BYTES);
                        remaining <= remaining - LEN_W'(1);
                        if (beat_cnt == BEAT_W'(1)) begin
                            m_axi_bready <= 1'b1;
                            state        <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        err_acc      <= err_acc | (m_axi_bresp != AXI_RESP_OKAY);
                        state        <= (remaining != '0) ? ST_CALC : ST_DONE;
                    end
                end
                ST_DONE: begin
                    wr_done <= 1'b1;
                    wr_err  <= err_acc;
                    wr_busy <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Directed bench for axi_burst_write_master: bench-side FIFO/AXI slave, burst-split model and scoreboard.
module tb_axi_burst_write_master;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 16;
    localparam int MAX_BURST = 16;
    localparam int BYTES     = DATA_W / 8;

    logic              clk;
    logic              rst_n;
    logic              wr_start;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  wr_len;
    logic              wr_done, wr_err, wr_busy;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst;
    logic              m_axi_awvalid, m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [BYTES-1:0]  m_axi_wstrb;
    logic              m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid, m_axi_bready;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_empty, fifo_ren;

    axi_burst_write_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_done(wr_done), .wr_err(wr_err), .wr_busy(wr_busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  l;
    } burst_t;

    burst_t      exp_aw[$];
    logic [31:0] exp_d[$];
    logic [31:0] fifo_q[$];
    logic [31:0] src_q[$];

    int n_pass = 0;
    int n_tot  = 0;

    int          beats_left = 0;
    int          ren_cnt = 0;
    int          obs_n = 0;
    logic [31:0] obs_a[8];
    logic [7:0]  obs_l[8];
    bit          hs_aw_r = 0, hs_w_r = 0, hs_b_r = 0, wlast_r = 0;
    bit          prev_aw_wait = 0, prev_w_wait = 0;
    logic [31:0] prev_awaddr, prev_wdata;
    logic [7:0]  prev_awlen;
    bit          done_seen = 0, err_at_done = 0, xfer_active = 0;

    bit rnd_mode = 0, stall_mode = 0;
    int stall_cnt = 0, pushed = 0, b_pending = 0, b_idx = 0, err_burst = -1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endfunction

    // Reference split: walk the transfer, each burst ends at MAX_BURST, at the 4 KB page or at the end
    task automatic model_bursts(input logic [31:0] addr, input int len);
        logic [31:0] a;
        int rem, page, b;
        burst_t t;
        a   = addr & ~32'(BYTES - 1);
        rem = len;
        while (rem > 0) begin
            page = (4096 - int'(a[11:0])) / BYTES;
            b = rem;
            if (b > MAX_BURST) b = MAX_BURST;
            if (b > page) b = page;
            t.a = a;
            t.l = 8'(b - 1);
            exp_aw.push_back(t);
            a   = a + 32'(b * BYTES);
            rem = rem - b;
        end
    endtask

    // Monitor/scoreboard: samples on the falling edge, inputs change only just after the rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            hs_aw_r = 0; hs_w_r = 0; hs_b_r = 0; wlast_r = 0;
            prev_aw_wait = 0; prev_w_wait = 0;
        end else begin
            chk("fifo_ren", fifo_ren, m_axi_wvalid & m_axi_wready);
            chk("aw_w_overlap", m_axi_awvalid & m_axi_wvalid, 0);
            if (fifo_empty) chk("wvalid_while_empty", m_axi_wvalid, 0);
            if (m_axi_wvalid) begin
                chk("wdata_head", m_axi_wdata, fifo_rdata);
                chk("wstrb", m_axi_wstrb, 4'hF);
            end
            if (m_axi_awvalid) begin
                chk("awsize", m_axi_awsize, 3'd2);
                chk("awburst", m_axi_awburst, 2'b01);
            end
            if (prev_aw_wait) begin
                chk("aw_hold_valid", m_axi_awvalid, 1);
                chk("aw_hold_addr", m_axi_awaddr, prev_awaddr);
                chk("aw_hold_len", m_axi_awlen, prev_awlen);
            end
            if (prev_w_wait) begin
                chk("w_hold_valid", m_axi_wvalid, 1);
                chk("w_hold_data", m_axi_wdata, prev_wdata);
            end
            hs_aw_r = m_axi_awvalid && m_axi_awready;
            hs_w_r  = m_axi_wvalid && m_axi_wready;
            hs_b_r  = m_axi_bvalid && m_axi_bready;
            wlast_r = m_axi_wlast;
            if (hs_aw_r) begin
                chk("aw_expected", exp_aw.size() > 0, 1);
                chk("aw_while_w_open", beats_left, 0);
                if (exp_aw.size() > 0) begin
                    burst_t t;
                    t = exp_aw.pop_front();
                    chk("awaddr", m_axi_awaddr, t.a);
                    chk("awlen", m_axi_awlen, t.l);
                    beats_left = int'(t.l) + 1;
                end
                if (obs_n < 8) begin
                    obs_a[obs_n] = m_axi_awaddr;
                    obs_l[obs_n] = m_axi_awlen;
                end
                obs_n++;
            end
            if (hs_w_r) begin
                chk("w_after_aw", beats_left > 0, 1);
                if (beats_left > 0) begin
                    chk("wlast", m_axi_wlast, beats_left == 1);
                    beats_left--;
                end
                chk("w_data_expected", exp_d.size() > 0, 1);
                if (exp_d.size() > 0) chk("wdata_order", m_axi_wdata, exp_d.pop_front());
                ren_cnt++;
            end
            if (wr_done) begin
                chk("done_expected", wr_done, xfer_active);
                chk("busy_at_done", wr_busy, 0);
                done_seen   = 1;
                err_at_done = wr_err;
                xfer_active = 0;
            end
            prev_aw_wait = m_axi_awvalid && !m_axi_awready;
            prev_awaddr  = m_axi_awaddr;
            prev_awlen   = m_axi_awlen;
            prev_w_wait  = m_axi_wvalid && !m_axi_wready;
            prev_wdata   = m_axi_wdata;
        end
    end

    // FIFO and AXI slave model
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (hs_b_r) begin
                m_axi_bvalid = 0;
                m_axi_bresp  = 2'b00;
                b_pending--;
                b_idx++;
            end
            if (hs_w_r) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                if (wlast_r) b_pending++;
            end
            if (!stall_mode) begin
                while (src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
            end else if (src_q.size() > 0) begin
                if (stall_cnt > 0) stall_cnt--;
                else begin
                    fifo_q.push_back(src_q.pop_front());
                    pushed++;
                    if (pushed == 6) stall_cnt = 8;
                end
            end
            m_axi_awready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_wready  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!m_axi_bvalid && b_pending > 0 && (!rnd_mode || $urandom_range(0, 2) == 0)) begin
                m_axi_bvalid = 1;
                m_axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
            end
        end
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = fifo_empty ? '0 : fifo_q[0];
    end

    task automatic setup_xfer(input logic [31:0] addr, input int len, input int errb,
                              input bit rnd, input bit stall);
        logic [31:0] d;
        model_bursts(addr, len);
        for (int i = 0; i < len; i++) begin
            d = $urandom;
            exp_d.push_back(d);
            src_q.push_back(d);
        end
        rnd_mode = rnd; stall_mode = stall; err_burst = errb;
        b_idx = 0; ren_cnt = 0; obs_n = 0; stall_cnt = 0; pushed = 0;
        done_seen = 0; err_at_done = 0; xfer_active = 1;
        @(posedge clk);
        #1;
        wr_start = 1; wr_addr = addr; wr_len = LEN_W'(len);
        @(posedge clk);
        #1;
        wr_start = 0;
    endtask

    task automatic run_xfer(input logic [31:0] addr, input int len, input int errb,
                            input bit rnd, input bit stall, input bit restart);
        int cyc;
        setup_xfer(addr, len, errb, rnd, stall);
        cyc = 0;
        while (!done_seen && cyc < 3000) begin
            @(negedge clk);
            #1;
            cyc++;
            if (cyc == 1) chk("busy_after_start", wr_busy, 1);
            if (restart && cyc == 4) begin
                wr_start = 1; wr_addr = 32'h500; wr_len = 16'd7;
            end
            if (restart && cyc == 5) wr_start = 0;
        end
        wr_start = 0;
        chk("done_within_budget", done_seen, 1);
        if (len == 0) chk("zero_len_latency", cyc, 2);
        chk("wr_err", err_at_done, errb >= 0);
        chk("bursts_left", exp_aw.size(), 0);
        chk("beats_left", exp_d.size(), 0);
        chk("fifo_ren_count", ren_cnt, len);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int cyc;
        rst_n = 0; wr_start = 0; wr_addr = '0; wr_len = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1;
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_done", wr_done, 0);
        chk("rst_err", wr_err, 0);
        chk("rst_busy", wr_busy, 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        chk("rst_awlen", m_axi_awlen, 0);
        chk("rst_fifo_ren", fifo_ren, 0);

        run_xfer(32'h1000, 1, -1, 0, 0, 0);
        chk("t1_nbursts", obs_n, 1);
        chk("t1_awaddr", obs_a[0], 32'h1000);
        chk("t1_awlen", obs_l[0], 8'd0);

        run_xfer(32'h0, 20, -1, 0, 0, 1);
        chk("t2_nbursts", obs_n, 2);
        chk("t2_awaddr0", obs_a[0], 32'h0);
        chk("t2_awlen0", obs_l[0], 8'd15);
        chk("t2_awaddr1", obs_a[1], 32'h40);
        chk("t2_awlen1", obs_l[1], 8'd3);

        run_xfer(32'hFF8, 4, -1, 0, 0, 0);
        chk("t3_nbursts", obs_n, 2);
        chk("t3_awaddr0", obs_a[0], 32'hFF8);
        chk("t3_awlen0", obs_l[0], 8'd1);
        chk("t3_awaddr1", obs_a[1], 32'h1000);
        chk("t3_awlen1", obs_l[1], 8'd1);

        run_xfer(32'h2000, 24, -1, 1, 1, 0);

        run_xfer(32'h3010, 20, 0, 1, 0, 0);
        chk("t5_nbursts", obs_n, 2);
        chk("t5_awaddr1", obs_a[1], 32'h3050);

        run_xfer(32'h4000, 0, -1, 0, 0, 0);
        chk("t6_no_aw", obs_n, 0);

        // Reset in the middle of the W phase
        setup_xfer(32'h5000, 20, -1, 0, 1);
        cyc = 0;
        while (ren_cnt < 3 && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("rst_mid_reached_w", ren_cnt >= 3, 1);
        xfer_active = 0;
        rst_n = 0;
        #1;
        chk("mid_rst_awvalid", m_axi_awvalid, 0);
        chk("mid_rst_wvalid", m_axi_wvalid, 0);
        chk("mid_rst_bready", m_axi_bready, 0);
        chk("mid_rst_busy", wr_busy, 0);
        chk("mid_rst_done", wr_done, 0);
        chk("mid_rst_fifo_ren", fifo_ren, 0);
        repeat (2) @(posedge clk);
        exp_aw.delete(); exp_d.delete(); src_q.delete(); fifo_q.delete();
        beats_left = 0; b_pending = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00; stall_mode = 0;
        @(negedge clk);
        #1;
        rst_n = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_awvalid", m_axi_awvalid, 0);
        chk("post_rst_busy", wr_busy, 0);

        run_xfer(32'h1FFE, 5, -1, 1, 0, 0);
        chk("t8_nbursts", obs_n, 2);
        chk("t8_awaddr0", obs_a[0], 32'h1FFC);
        chk("t8_awlen0", obs_l[0], 8'd0);
        chk("t8_awaddr1", obs_a[1], 32'h2000);
        chk("t8_awlen1", obs_l[1], 8'd3);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
